// File: rtl/bram_window_streamer.sv
// Single-frame buffer that streams KERNEL_WIDTH vertically adjacent pixels
// per beat to the convolution stage. It supports optional zero padding,
// downstream backpressure and re-streaming of the stored frame.
module bram_window_streamer #(
    parameter int RAM_WIDTH    = 8,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3,
    parameter int PAD_MODE     = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_load_valid,
    input  logic [RAM_WIDTH-1:0]              i_data_to_mem,
    input  logic                              i_start,
    input  logic                              i_conv_ready,
    output logic [KERNEL_WIDTH*RAM_WIDTH-1:0] o_to_conv,
    output logic                              o_valid_data_to_conv,
    output logic                              o_load_done,
    output logic                              o_busy,
    output logic                              o_frame_done
);

    localparam int NPIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int OFF       = (PAD_MODE != 0) ? (KERNEL_WIDTH - 1) / 2 : 0;
    localparam int OUT_H     = (PAD_MODE != 0) ? IMAGE_HEIGHT : IMAGE_HEIGHT - KERNEL_WIDTH + 1;
    // One spare row per bank so window rows just below the frame still index inside a bank.
    localparam int BANK_ROWS = (IMAGE_HEIGHT + KERNEL_WIDTH - 1) / KERNEL_WIDTH + 1;
    localparam int DEPTH     = BANK_ROWS * IMAGE_WIDTH;
    localparam int DW        = $clog2(DEPTH);
    localparam int AW        = $clog2(DEPTH + IMAGE_WIDTH);
    localparam int PW        = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int BW        = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
    localparam int TW        = $clog2(IMAGE_HEIGHT + KERNEL_WIDTH) + 2;
    localparam int INIT_BANK0 = (OFF == 0) ? 0 : KERNEL_WIDTH - OFF;
    // Banks whose first window row lies above the frame start one bank-row "before" 0;
    // the first row advance wraps their base back to 0.
    localparam logic [AW-1:0] NEG_W = AW'(-IMAGE_WIDTH);

    typedef enum logic [1:0] {S_EMPTY, S_LOADED, S_STREAM} state_t;

    state_t                 state_q, state_d;
    logic                   wr_en, start_go, issue, last_accept;

    logic [PW-1:0]          wr_ptr_q;
    logic [CW-1:0]          wr_col_q;
    logic [BW-1:0]          wr_bank_q;
    logic [DW-1:0]          wr_base_q;
    logic [DW-1:0]          wr_addr;

    logic                   prime_q, issued_all_q, valid_q, frame_done_q;
    logic [CW-1:0]          rd_col_q;
    logic [RW-1:0]          rd_row_q;
    logic signed [TW-1:0]   rd_top_q;
    logic [BW-1:0]          bank0_q, sel0_q;
    logic [AW-1:0]          rd_base_q [KERNEL_WIDTH];
    logic [AW-1:0]          rd_addr   [KERNEL_WIDTH];
    logic [KERNEL_WIDTH-1:0] lane_ok_d, lane_ok_q;
    logic [BW:0]            lane_tmp;
    logic [BW-1:0]          lane_sel  [KERNEL_WIDTH];

    logic [RAM_WIDTH-1:0]   mem_q     [KERNEL_WIDTH][DEPTH];
    logic [RAM_WIDTH-1:0]   bank_rd_q [KERNEL_WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        start_go    = 1'b0;
        issue       = 1'b0;
        last_accept = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (i_load_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == PW'(NPIX - 1)) state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (i_start) begin
                    start_go = 1'b1;
                    state_d  = S_STREAM;
                end else if (i_load_valid) begin
                    wr_en   = 1'b1;
                    state_d = S_EMPTY;
                end
            end
            S_STREAM: begin
                issue = !prime_q && !issued_all_q && (!valid_q || i_conv_ready);
                if (issued_all_q && valid_q && i_conv_ready) begin
                    last_accept = 1'b1;
                    state_d     = S_LOADED;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Raster write pointer, split into column, bank and bank-row base.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            wr_col_q  <= '0;
            wr_bank_q <= '0;
            wr_base_q <= '0;
        end else if (wr_en) begin
            if (wr_ptr_q == PW'(NPIX - 1)) begin
                wr_ptr_q  <= '0;
                wr_col_q  <= '0;
                wr_bank_q <= '0;
                wr_base_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (wr_col_q == CW'(IMAGE_WIDTH - 1)) begin
                    wr_col_q <= '0;
                    if (wr_bank_q == BW'(KERNEL_WIDTH - 1)) begin
                        wr_bank_q <= '0;
                        wr_base_q <= wr_base_q + DW'(IMAGE_WIDTH);
                    end else begin
                        wr_bank_q <= wr_bank_q + BW'(1);
                    end
                end else begin
                    wr_col_q <= wr_col_q + CW'(1);
                end
            end
        end
    end

    // Bank write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_addr] <= i_data_to_mem;
    end

    // Write address and per-bank read addresses, lane validity for the current window row.
    always_comb begin
        wr_addr   = wr_base_q + DW'(wr_col_q);
        lane_ok_d = '0;
        for (int unsigned k = 0; k < KERNEL_WIDTH; k++) begin
            rd_addr[k]   = rd_base_q[k] + AW'(rd_col_q);
            lane_ok_d[k] = (int'(rd_top_q) + int'(k) >= 0) &&
                           (int'(rd_top_q) + int'(k) < IMAGE_HEIGHT);
        end
    end

    // Stream address generation and output-beat handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_q      <= 1'b0;
            issued_all_q <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            rd_col_q     <= '0;
            rd_row_q     <= '0;
            rd_top_q     <= '0;
            bank0_q      <= '0;
            sel0_q       <= '0;
            lane_ok_q    <= '0;
            for (int unsigned b = 0; b < KERNEL_WIDTH; b++) rd_base_q[b] <= '0;
        end else begin
            frame_done_q <= last_accept;
            prime_q      <= start_go;
            if (start_go) begin
                issued_all_q <= 1'b0;
                rd_col_q     <= '0;
                rd_row_q     <= '0;
                rd_top_q     <= TW'(-OFF);
                bank0_q      <= BW'(INIT_BANK0);
                for (int unsigned b = 0; b < KERNEL_WIDTH; b++)
                    rd_base_q[b] <= (int'(b) >= KERNEL_WIDTH - OFF) ? NEG_W : '0;
            end else if (issue) begin
                sel0_q    <= bank0_q;
                lane_ok_q <= lane_ok_d;
                if (rd_col_q == CW'(IMAGE_WIDTH - 1)) begin
                    rd_col_q <= '0;
                    if (rd_row_q == RW'(OUT_H - 1)) begin
                        issued_all_q <= 1'b1;
                    end else begin
                        // The bank that held the top row now supplies the new bottom row.
                        rd_row_q           <= rd_row_q + RW'(1);
                        rd_top_q           <= rd_top_q + TW'(1);
                        rd_base_q[bank0_q] <= rd_base_q[bank0_q] + AW'(IMAGE_WIDTH);
                        bank0_q <= (bank0_q == BW'(KERNEL_WIDTH - 1)) ? '0 : bank0_q + BW'(1);
                    end
                end else begin
                    rd_col_q <= rd_col_q + CW'(1);
                end
            end
            if (issue)             valid_q <= 1'b1;
            else if (i_conv_ready) valid_q <= 1'b0;
        end
    end

    // Registered bank reads; holding the read register is what stalls the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < KERNEL_WIDTH; b++) bank_rd_q[b] <= '0;
        end else if (issue) begin
            for (int unsigned b = 0; b < KERNEL_WIDTH; b++)
                bank_rd_q[b] <= (rd_addr[b] < AW'(DEPTH)) ? mem_q[b][rd_addr[b][DW-1:0]] : '0;
        end
    end

    // Lane-to-bank rotation, padding mask and status outputs.
    always_comb begin
        o_to_conv = '0;
        lane_tmp  = '0;
        for (int unsigned k = 0; k < KERNEL_WIDTH; k++) begin
            lane_tmp = {1'b0, sel0_q} + (BW+1)'(k);
            if (lane_tmp >= (BW+1)'(KERNEL_WIDTH)) lane_tmp = lane_tmp - (BW+1)'(KERNEL_WIDTH);
            lane_sel[k] = lane_tmp[BW-1:0];
            if (lane_ok_q[k]) o_to_conv[k*RAM_WIDTH +: RAM_WIDTH] = bank_rd_q[lane_sel[k]];
        end
        o_valid_data_to_conv = valid_q;
        o_load_done          = (state_q != S_EMPTY);
        o_busy               = (state_q == S_STREAM);
        o_frame_done         = frame_done_q;
    end

endmodule
